xintf_hb_master: RTL and testbench

Bus-master that drives DSP external-interface (XINTF) write cycles on zone 6 toward the FPGA-side DSP fault monitor, and generates the periodic heartbeat writes that monitor expects. Heartbeat writes go to 0x03A5 (healthy) or 0x035A (interrupt fault). Generic single-word writes are also accepted through a valid/ready request port. The block sits in the DSP-emulation / board-test path, so the fault-check logic can be exercised and run in closed loop without a real DSP.

---
 rtl/xintf_hb_master_if.sv | 7 +
 rtl/xintf_hb_master.sv | 68 ++++++
 tb/tb_xintf_hb_master.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/xintf_hb_master_if.sv
// xintf_hb_master_if: request handshake and XINTF zone-6 write bus of the heartbeat master
interface xintf_hb_master_if;
  logic        req_valid, req_ready, XZCS6, XWE, DSP_D_oe;
  logic [15:0] req_addr, req_data, DSP_A, DSP_D;
  modport master(input req_valid, req_addr, req_data, output req_ready, XZCS6, XWE, DSP_A, DSP_D, DSP_D_oe);
  modport slave(output req_valid, req_addr, req_data, input req_ready, XZCS6, XWE, DSP_A, DSP_D, DSP_D_oe);
endinterface

// File: rtl/xintf_hb_master.sv
// xintf_hb_master: XINTF zone-6 write master issuing periodic heartbeat writes and generic single-word writes
module xintf_hb_master #(
  parameter int          HB_PERIOD  = 3120,
  parameter int          LEAD       = 2,
  parameter int          ACTIVE     = 3,
  parameter int          TRAIL      = 1,
  parameter logic [15:0] ADDR_OK    = 16'h03A5,
  parameter logic [15:0] ADDR_FAULT = 16'h035A
) (
  input  logic clk_20M,
  input  logic reset,
  input  logic hb_en,
  input  logic fault_flag,
  output logic done,
  output logic hb_miss,
  xintf_hb_master_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_ACTIVE, S_TRAIL} state_t;
  state_t      state, state_n;
  logic [7:0]  phase, phase_n;
  logic [15:0] hb_cnt, hb_seq;
  logic        hb_pend, launch_hb, launch_req, wrap, last;
  assign bus.req_ready = state == S_IDLE && !hb_pend;
  always_comb begin
    last = phase == (state == S_LEAD ? 8'(LEAD - 1) : state == S_ACTIVE ? 8'(ACTIVE - 1) : 8'(TRAIL - 1));
    launch_hb = state == S_IDLE && hb_pend;
    launch_req = bus.req_ready && bus.req_valid;
    wrap = hb_en && hb_cnt == 16'(HB_PERIOD - 1);
    state_n = state == S_IDLE ? ((launch_hb || launch_req) ? S_LEAD : S_IDLE) :
              !last ? state : state == S_LEAD ? S_ACTIVE : state == S_ACTIVE ? S_TRAIL : S_IDLE;
    phase_n = (state == S_IDLE || last) ? 8'd0 : phase + 8'd1;
  end
  // bus pins are registered from the next state so they switch on the same edge as the FSM
  always_ff @(posedge clk_20M) begin
    if (reset) begin
      state <= S_IDLE;
      phase <= 8'd0;
      hb_cnt <= 16'd0;
      hb_seq <= 16'd0;
      hb_pend <= 1'b0;
      hb_miss <= 1'b0;
      done <= 1'b0;
      bus.XZCS6 <= 1'b1;
      bus.XWE <= 1'b1;
      bus.DSP_D_oe <= 1'b0;
      bus.DSP_A <= 16'd0;
      bus.DSP_D <= 16'd0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      hb_cnt <= (!hb_en || wrap) ? 16'd0 : hb_cnt + 16'd1;
      hb_pend <= hb_en && (wrap || (hb_pend && !launch_hb));
      hb_miss <= wrap && hb_pend && !launch_hb;
      hb_seq <= hb_seq + 16'(launch_hb);
      done <= state == S_TRAIL && state_n == S_IDLE;
      bus.XZCS6 <= state_n == S_IDLE;
      bus.XWE <= state_n != S_ACTIVE;
      bus.DSP_D_oe <= state_n != S_IDLE;
      if (launch_hb) begin
        bus.DSP_A <= fault_flag ? ADDR_FAULT : ADDR_OK;
        bus.DSP_D <= hb_seq;
      end else if (launch_req) begin
        bus.DSP_A <= bus.req_addr;
        bus.DSP_D <= bus.req_data;
      end
    end
  end
endmodule

// File: tb/tb_xintf_hb_master.sv
// tb_xintf_hb_master: directed checks of bus timing, heartbeat cadence, priority, miss detection and reset
module tb_xintf_hb_master;
  logic clk_20M = 0, reset = 1, hb_en = 0, fault_flag = 0, hb_en4 = 0;
  logic done, hb_miss, done4, hb_miss4;
  int   checks = 0, errors = 0;
  xintf_hb_master_if b();
  xintf_hb_master_if b4();
  xintf_hb_master dut (.clk_20M(clk_20M), .reset(reset), .hb_en(hb_en), .fault_flag(fault_flag),
                       .done(done), .hb_miss(hb_miss), .bus(b));
  xintf_hb_master #(.HB_PERIOD(4)) dut4 (.clk_20M(clk_20M), .reset(reset), .hb_en(hb_en4), .fault_flag(1'b0),
                                         .done(done4), .hb_miss(hb_miss4), .bus(b4));
  always #25 clk_20M = ~clk_20M;
  task automatic tick(input int n);
    repeat (n) @(posedge clk_20M);
    #1;
  endtask
  task automatic wait_fall(output int n);
    logic prev;
    n = 0;
    prev = b.XZCS6;
    while (n < 5000) begin
      tick(1);
      n++;
      if (prev === 1'b1 && b.XZCS6 === 1'b0) break;
      prev = b.XZCS6;
    end
  endtask
  task automatic test_reset;
    logic [37:0] exp, got;
    b.req_valid = 0; b.req_addr = 0; b.req_data = 0;
    b4.req_valid = 0; b4.req_addr = 0; b4.req_data = 0;
    reset = 1;
    tick(3);
    reset = 0;
    exp = {6'b110001, 32'h0};
    for (int i = 0; i < 20; i++) begin
      tick(1);
      got = {b.XZCS6, b.XWE, b.DSP_D_oe, done, hb_miss, b.req_ready, b.DSP_A, b.DSP_D};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL reset_idle cycle %0d got %h exp %h", i, got, exp); end
    end
  endtask
  task automatic test_write;
    logic [35:0] exp, got;
    b.req_valid = 1; b.req_addr = 16'h1234; b.req_data = 16'hBEEF;
    checks++;
    if (b.req_ready !== 1'b1) begin errors++; $display("FAIL write_ready got %b exp 1", b.req_ready); end
    tick(1);
    b.req_valid = 0;
    for (int i = 0; i < 8; i++) begin
      exp = {i >= 6, !(i >= 2 && i < 5), i < 6, i == 6, 16'h1234, 16'hBEEF};
      got = {b.XZCS6, b.XWE, b.DSP_D_oe, done, b.DSP_A, b.DSP_D};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL write_cycle %0d got %h exp %h", i, got, exp); end
      tick(1);
    end
  endtask
  task automatic test_heartbeat;
    int n;
    logic [31:0] exp;
    reset = 1;
    tick(1);
    reset = 0; hb_en = 1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) fault_flag = 1;
      wait_fall(n);
      checks++;
      if (n != (k == 0 ? 3121 : 3120)) begin errors++; $display("FAIL hb_spacing %0d got %0d exp %0d", k, n, k == 0 ? 3121 : 3120); end
      exp = {k == 3 ? 16'h035A : 16'h03A5, 16'(k)};
      checks++;
      if ({b.DSP_A, b.DSP_D} !== exp) begin errors++; $display("FAIL hb_write %0d got %h exp %h", k, {b.DSP_A, b.DSP_D}, exp); end
    end
    fault_flag = 0;
  endtask
  task automatic test_priority;
    logic [2:0] got, exp;
    tick(3119);
    b.req_valid = 1; b.req_addr = 16'hC0DE; b.req_data = 16'h0042;
    checks++;
    if (b.req_ready !== 1'b0) begin errors++; $display("FAIL prio_ready_tick got %b exp 0", b.req_ready); end
    tick(1);
    checks++;
    if ({b.XZCS6, b.DSP_A, b.DSP_D} !== {1'b0, 16'h03A5, 16'h0004}) begin
      errors++; $display("FAIL prio_hb_first got %h exp %h", {b.XZCS6, b.DSP_A, b.DSP_D}, {1'b0, 16'h03A5, 16'h0004});
    end
    for (int i = 0; i < 7; i++) begin
      exp = {3{i == 6}};
      got = {b.XZCS6, b.req_ready, done};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL prio_hold %0d got %b exp %b", i, got, exp); end
      if (i < 6) tick(1);
    end
    tick(1);
    checks++;
    if ({b.XZCS6, b.DSP_A, b.DSP_D} !== {1'b0, 16'hC0DE, 16'h0042}) begin
      errors++; $display("FAIL prio_req_next got %h exp %h", {b.XZCS6, b.DSP_A, b.DSP_D}, {1'b0, 16'hC0DE, 16'h0042});
    end
    b.req_valid = 0;
    tick(8);
    hb_en = 0;
    tick(2);
  endtask
  task automatic test_back_to_back_miss;
    logic [32:0] exp;
    hb_en4 = 1; b4.req_valid = 1; b4.req_addr = 16'h5555; b4.req_data = 16'hAAAA;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      checks++;
      if ({hb_miss4, b4.req_ready} !== {i == 12 || i == 20 || i == 28, 1'b0}) begin
        errors++; $display("FAIL miss_cycle %0d got %b%b exp %b0", i, hb_miss4, b4.req_ready, i == 12 || i == 20 || i == 28);
      end
      if (i % 7 == 0) begin
        checks++;
        if ({b4.XZCS6, done4} !== 2'b11) begin errors++; $display("FAIL miss_gap %0d got %b%b exp 11", i, b4.XZCS6, done4); end
      end
      if (i == 1 || i % 7 == 1) begin
        exp = i == 1 ? {1'b0, 16'h5555, 16'hAAAA} : {1'b0, 16'h03A5, 16'((i - 8) / 7)};
        checks++;
        if ({b4.XZCS6, b4.DSP_A, b4.DSP_D} !== exp) begin
          errors++; $display("FAIL miss_launch %0d got %h exp %h", i, {b4.XZCS6, b4.DSP_A, b4.DSP_D}, exp);
        end
      end
    end
    hb_en4 = 0; b4.req_valid = 0;
    tick(10);
  endtask
  task automatic test_reset_mid;
    int n;
    hb_en = 1; b.req_valid = 1; b.req_addr = 16'h7777; b.req_data = 16'h1111;
    tick(1);
    b.req_valid = 0;
    tick(2);
    checks++;
    if ({b.XZCS6, b.XWE} !== 2'b00) begin errors++; $display("FAIL rmid_active got %b%b exp 00", b.XZCS6, b.XWE); end
    reset = 1;
    tick(1);
    reset = 0;
    checks++;
    if ({b.XZCS6, b.XWE, done, b.DSP_D_oe, b.DSP_A} !== {4'b1100, 16'h0}) begin
      errors++; $display("FAIL rmid_after got %h exp %h", {b.XZCS6, b.XWE, done, b.DSP_D_oe, b.DSP_A}, {4'b1100, 16'h0});
    end
    wait_fall(n);
    checks++;
    if (n != 3121) begin errors++; $display("FAIL rmid_hb_cnt got %0d exp 3121", n); end
    checks++;
    if ({b.DSP_A, b.DSP_D} !== {16'h03A5, 16'h0000}) begin
      errors++; $display("FAIL rmid_hb_seq got %h exp %h", {b.DSP_A, b.DSP_D}, {16'h03A5, 16'h0000});
    end
    hb_en = 0;
    tick(10);
  endtask
  initial begin
    test_reset;
    test_write;
    test_heartbeat;
    test_priority;
    test_back_to_back_miss;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
